reservation_station: RTL

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - reservation station with CDB wakeup and a registered ALU dispatch stage
// Define RS_OLDEST_FIRST_EN to dispatch the oldest ready entry instead of the lowest-index one.
module reservation_station #(
  parameter int RS_SIZE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clr,
  input  logic                      issue_valid,
  input  logic [31:0]               issue_rd,
  input  logic [31:0]               issue_vj,
  input  logic [31:0]               issue_vk,
  input  logic [31:0]               issue_qj,
  input  logic [31:0]               issue_qk,
  input  logic [31:0]               issue_imm,
  input  logic [31:0]               issue_tag,
  input  logic [16:0]               issue_name,
  output logic                      full,
  output logic [$clog2(RS_SIZE):0]  occupancy,
  input  logic                      cdb_valid,
  input  logic [31:0]               cdb_tag,
  input  logic [31:0]               cdb_value,
  output logic                      alu_valid,
  output logic [16:0]               alu_name,
  output logic [31:0]               alu_vj,
  output logic [31:0]               alu_vk,
  output logic [31:0]               alu_imm,
  output logic [31:0]               alu_rd,
  output logic [31:0]               alu_tag,
  input  logic                      alu_ready
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;

  logic [RS_SIZE-1:0] busy;
  logic [16:0]        e_name [RS_SIZE];
  logic [31:0]        e_vj   [RS_SIZE];
  logic [31:0]        e_vk   [RS_SIZE];
  logic [31:0]        e_qj   [RS_SIZE];
  logic [31:0]        e_qk   [RS_SIZE];
  logic [31:0]        e_imm  [RS_SIZE];
  logic [31:0]        e_rd   [RS_SIZE];
  logic [31:0]        e_tag  [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] wake_j;
  logic [RS_SIZE-1:0] wake_k;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      sel_idx;
  logic               sel_found;
  logic               flush;
  logic               load;
  logic               dispatch;
  logic               accept;
  logic               iss_wake_j;
  logic               iss_wake_k;

`ifdef RS_OLDEST_FIRST_EN
  logic [IW-1:0]      e_age [RS_SIZE];
  logic [IW-1:0]      best_age;
  logic [IW-1:0]      sel_age;
`endif

  always_comb begin
    occupancy = '0;
    ready     = '0;
    wake_j    = '0;
    wake_k    = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      occupancy = occupancy + CW'(busy[i]);
      ready[i]  = busy[i] && (e_qj[i] == '0) && (e_qk[i] == '0);
      wake_j[i] = busy[i] && cdb_valid && (cdb_tag != '0) && (e_qj[i] == cdb_tag);
      wake_k[i] = busy[i] && cdb_valid && (cdb_tag != '0) && (e_qk[i] == cdb_tag);
    end
  end

  assign full       = (occupancy == CW'(RS_SIZE));
  assign flush      = rst || (rdy && clr);
  assign load       = !alu_valid || alu_ready;
  assign dispatch   = load && sel_found;
  assign accept     = issue_valid && !full;
  assign iss_wake_j = cdb_valid && (cdb_tag != '0) && (issue_qj == cdb_tag);
  assign iss_wake_k = cdb_valid && (cdb_tag != '0) && (issue_qk == cdb_tag);

  // Slot choice uses pre-edge busy bits, so a slot freed by dispatch is never reused on that edge.
  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!busy[i]) free_idx = IW'(i);
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && (!sel_found || (e_age[i] > best_age))) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        best_age  = e_age[i];
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      busy      <= '0;
      alu_valid <= 1'b0;
      alu_name  <= '0;
      alu_vj    <= '0;
      alu_vk    <= '0;
      alu_imm   <= '0;
      alu_rd    <= '0;
      alu_tag   <= '0;
    end else if (rdy) begin
      if (load) begin
        alu_valid <= sel_found;
        if (sel_found) begin
          alu_name <= e_name[sel_idx];
          alu_vj   <= e_vj[sel_idx];
          alu_vk   <= e_vk[sel_idx];
          alu_imm  <= e_imm[sel_idx];
          alu_rd   <= e_rd[sel_idx];
          alu_tag  <= e_tag[sel_idx];
        end
      end
      if (dispatch) busy[sel_idx] <= 1'b0;
      if (accept) busy[free_idx] <= 1'b1;
    end
  end

  // Entry payload needs no reset: it is only observed while the busy bit is set.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (wake_j[i]) begin
          e_vj[i] <= cdb_value;
          e_qj[i] <= '0;
        end
        if (wake_k[i]) begin
          e_vk[i] <= cdb_value;
          e_qk[i] <= '0;
        end
      end
      if (accept) begin
        e_name[free_idx] <= issue_name;
        e_vj[free_idx]   <= iss_wake_j ? cdb_value : issue_vj;
        e_qj[free_idx]   <= iss_wake_j ? '0 : issue_qj;
        e_vk[free_idx]   <= iss_wake_k ? cdb_value : issue_vk;
        e_qk[free_idx]   <= iss_wake_k ? '0 : issue_qk;
        e_imm[free_idx]  <= issue_imm;
        e_rd[free_idx]   <= issue_rd;
        e_tag[free_idx]  <= issue_tag;
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  assign sel_age = e_age[sel_idx];

  // Ages stay a dense permutation of 0..occupancy-1; the largest is the oldest.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) e_age[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++)
        if (busy[i])
          e_age[i] <= e_age[i] + IW'(accept) - IW'(dispatch && (e_age[i] > sel_age));
      if (accept) e_age[free_idx] <= '0;
    end
  end
`endif

endmodule
